pbit_x_sampler: RTL and testbench

// Downstream p-bit stage of the VCBM_PA factorizer. Consumes the eight per-bit probability bit-planes from the energy calculator.

---
 rtl/pbit_x_sampler_if.sv | 39 +++
 rtl/pbit_x_sampler.sv | 120 ++++++++++++
 tb/tb_pbit_x_sampler.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pbit_x_sampler_if.sv
// Bundle between the p-bit X sampler and its controller: run request, probability
// bit-planes from the energy calculator, and the X result handshake.
interface pbit_x_sampler_if #(
  parameter int max_N_digit = 64
);
  localparam int XW = max_N_digit / 2;

  logic          start;
  logic [XW-1:0] x_init;
  logic [15:0]   num_iter;
  logic [6:0]    N_digit;
  logic [XW-2:0] pbit_in_0;
  logic [XW-2:0] pbit_in_1;
  logic [XW-2:0] pbit_in_2;
  logic [XW-2:0] pbit_in_3;
  logic [XW-2:0] pbit_in_4;
  logic [XW-2:0] pbit_in_5;
  logic [XW-2:0] pbit_in_6;
  logic [XW-2:0] pbit_in_7;
  logic [XW-1:0] X;
  logic          busy;
  logic          x_valid;
  logic          x_ready;
  logic [15:0]   iter_left;

  modport master (
    output start, x_init, num_iter, N_digit, x_ready,
    output pbit_in_0, pbit_in_1, pbit_in_2, pbit_in_3,
    output pbit_in_4, pbit_in_5, pbit_in_6, pbit_in_7,
    input  X, busy, x_valid, iter_left
  );

  modport slave (
    input  start, x_init, num_iter, N_digit, x_ready,
    input  pbit_in_0, pbit_in_1, pbit_in_2, pbit_in_3,
    input  pbit_in_4, pbit_in_5, pbit_in_6, pbit_in_7,
    output X, busy, x_valid, iter_left
  );
endinterface

// File: rtl/pbit_x_sampler.sv
// Parallel p-bit sampler: every X bit is redrawn against an 8-bit LFSR number each
// iteration, after a settle window that lets the energy calculator follow X.
module pbit_x_sampler #(
  parameter int          max_N_digit = 64,
  parameter int          SETTLE_CYC  = 3,
  parameter logic [31:0] SEED_BASE   = 32'h1ACE_B00C
) (
  input  logic             clk,
  input  logic             rst_n,
  pbit_x_sampler_if.slave  bus
);
  localparam int XW = max_N_digit / 2;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [31:0]   LFSR_POLY = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   iter_q, iter_d;
  logic [XW-1:0] x_q, x_d;
  logic [6:0]    ndig_q, ndig_d;
  logic [31:0]   lfsr_q [8];
  logic [XW-1:0] samp;

  function automatic logic [31:0] lfsr_seed(input int j);
    logic [31:0] s;
    s = SEED_BASE ^ (32'(j + 1) * 32'h9E37_79B9);
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'd0);
  endfunction

  // Keeps the low ceil(nd/2) bits of X.
  function automatic logic [XW-1:0] width_mask(input logic [6:0] nd);
    logic [XW-1:0] m;
    int            nb;
    nb = (int'(nd) + 1) / 2;
    for (int k = 0; k < XW; k++) m[k] = (k < nb);
    return m;
  endfunction

  function automatic logic sample_bit(input logic [7:0] w, input logic [7:0] r);
    return w[7] ? (r >= {1'b0, w[6:0]}) : (r < {1'b0, w[6:0]});
  endfunction

  assign samp[0] = 1'b1;
  for (genvar i = 0; i < XW - 1; i++) begin : g_lane
    logic [7:0] w, r;
    assign w = {bus.pbit_in_7[i], bus.pbit_in_6[i], bus.pbit_in_5[i], bus.pbit_in_4[i],
                bus.pbit_in_3[i], bus.pbit_in_2[i], bus.pbit_in_1[i], bus.pbit_in_0[i]};
    assign r = {lfsr_q[7][i], lfsr_q[6][i], lfsr_q[5][i], lfsr_q[4][i],
                lfsr_q[3][i], lfsr_q[2][i], lfsr_q[1][i], lfsr_q[0][i]};
    assign samp[i+1] = sample_bit(w, r);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    iter_d  = iter_q;
    x_d     = x_q;
    ndig_d  = ndig_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          cnt_d   = '0;
          iter_d  = (bus.num_iter == 16'd0) ? 16'd1 : bus.num_iter;
          x_d     = (bus.x_init & width_mask(bus.N_digit)) | XW'(1);
          ndig_d  = bus.N_digit;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SAMPLE: begin
        x_d     = (samp & width_mask(ndig_q)) | XW'(1);
        iter_d  = iter_q - 16'd1;
        state_d = (iter_q > 16'd1) ? SETTLE : DONE;
      end
      DONE: begin
        if (bus.x_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // LFSRs free-run in every state so the random stream depends only on time since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      iter_q  <= '0;
      x_q     <= XW'(1);
      ndig_q  <= 7'(max_N_digit);
      for (int j = 0; j < 8; j++) lfsr_q[j] <= lfsr_seed(j);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iter_q  <= iter_d;
      x_q     <= x_d;
      ndig_q  <= ndig_d;
      for (int j = 0; j < 8; j++) lfsr_q[j] <= lfsr_step(lfsr_q[j]);
    end
  end

  assign bus.X         = x_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.x_valid   = (state_q == DONE);
  assign bus.iter_left = iter_q;
endmodule

// File: tb/tb_pbit_x_sampler.sv
// Directed bench for pbit_x_sampler: reset state, deterministic plane values,
// masking, backpressure, sampling statistics and reset repeatability.
module tb_pbit_x_sampler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;
  logic [31:0] seq [2][9];

  pbit_x_sampler_if #(.max_N_digit(64)) bus ();

  pbit_x_sampler #(.max_N_digit(64), .SETTLE_CYC(3), .SEED_BASE(32'h1ACE_B00C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic set_w(input logic [7:0] w);
    bus.pbit_in_0 = {31{w[0]}};
    bus.pbit_in_1 = {31{w[1]}};
    bus.pbit_in_2 = {31{w[2]}};
    bus.pbit_in_3 = {31{w[3]}};
    bus.pbit_in_4 = {31{w[4]}};
    bus.pbit_in_5 = {31{w[5]}};
    bus.pbit_in_6 = {31{w[6]}};
    bus.pbit_in_7 = {31{w[7]}};
  endtask

  task automatic setup(input logic [31:0] xi, input logic [15:0] ni, input logic [6:0] nd,
                       input logic [7:0] w);
    bus.x_init = xi;
    bus.num_iter = ni;
    bus.N_digit = nd;
    set_w(w);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.x_valid && lat < 20000) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.x_valid) lat = -1;
  endtask

  task automatic accept();
    bus.x_ready = 1'b1;
    @(negedge clk);
    bus.x_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus.X !== 32'h1 || bus.busy !== 1'b0 || bus.x_valid !== 1'b0 || bus.iter_left !== 16'd0)
      $display("FAIL reset_state: X=%h busy=%b vld=%b iter=%0d want X=00000001 busy=0 vld=0 iter=0",
               bus.X, bus.busy, bus.x_valid, bus.iter_left);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mask_load();
    int lat;
    setup(32'h0000_00FE, 16'd0, 7'd7, 8'h80);
    pulse_start();
    bus.N_digit = 7'd64;
    bus.x_init = 32'hFFFF_FFFF;
    n_checks++;
    if (bus.X !== 32'h0000_000F) $display("FAIL mask_load: X=%h want 0000000f", bus.X);
    else n_pass++;
    n_checks++;
    if (bus.iter_left !== 16'd1) $display("FAIL zero_iter: iter_left=%0d want 1", bus.iter_left);
    else n_pass++;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n_checks++;
    if (bus.X !== 32'h0000_000F || bus.iter_left !== 16'd1)
      $display("FAIL start_in_settle: X=%h iter=%0d want 0000000f/1", bus.X, bus.iter_left);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat !== 3) $display("FAIL mask_latency: got %0d want 3", lat);
    else n_pass++;
    n_checks++;
    if (bus.X !== 32'h0000_000F) $display("FAIL mask_sample: X=%h want 0000000f", bus.X);
    else n_pass++;
    accept();
  endtask

  task automatic test_zero_planes();
    int lat;
    setup(32'hFFFF_FFFF, 16'd1, 7'd64, 8'h00);
    pulse_start();
    n_checks++;
    if (bus.X !== 32'hFFFF_FFFF || bus.busy !== 1'b1)
      $display("FAIL t1_load: X=%h busy=%b want ffffffff/1", bus.X, bus.busy);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat !== 4) $display("FAIL t1_latency: got %0d want 4", lat);
    else n_pass++;
    n_checks++;
    if (bus.X !== 32'h0000_0001) $display("FAIL t1_x: X=%h want 00000001", bus.X);
    else n_pass++;
    accept();
    n_checks++;
    if (bus.busy !== 1'b0 || bus.x_valid !== 1'b0)
      $display("FAIL t1_accept: busy=%b vld=%b want 0/0", bus.busy, bus.x_valid);
    else n_pass++;
  endtask

  task automatic test_full_planes();
    int lat;
    setup(32'h0, 16'd2, 7'd16, 8'h80);
    pulse_start();
    n_checks++;
    if (bus.X !== 32'h1 || bus.iter_left !== 16'd2)
      $display("FAIL t2_load: X=%h iter=%0d want 00000001/2", bus.X, bus.iter_left);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.iter_left !== 16'd1 || bus.X !== 32'h0000_00FF || bus.x_valid !== 1'b0)
      $display("FAIL t2_iter1: iter=%0d X=%h vld=%b want 1/000000ff/0", bus.iter_left, bus.X, bus.x_valid);
    else n_pass++;
    wait_valid(lat);
    n_checks++;
    if (lat !== 4 || bus.iter_left !== 16'd0 || bus.X !== 32'h0000_00FF)
      $display("FAIL t2_done: lat=%0d iter=%0d X=%h want 4/0/000000ff", lat, bus.iter_left, bus.X);
    else n_pass++;
    accept();
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    logic [31:0] xs;
    setup(32'h0, 16'd1, 7'd64, 8'h80);
    pulse_start();
    wait_valid(lat);
    xs = bus.X;
    n_checks++;
    if (lat !== 4 || xs !== 32'hFFFF_FFFF) $display("FAIL t4_result: lat=%0d X=%h want 4/ffffffff", lat, xs);
    else n_pass++;
    for (int k = 0; k < 10; k++) begin
      bus.start = (k % 2 == 0);
      bus.x_init = 32'h1234_5678;
      bus.num_iter = 16'd7;
      @(negedge clk);
      if (bus.x_valid !== 1'b1 || bus.X !== xs || bus.iter_left !== 16'd0) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL t4_hold: %0d unstable cycles, X=%h want %h", bad, bus.X, xs);
    else n_pass++;
    bus.start = 1'b1;
    bus.x_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x_ready = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.x_valid !== 1'b0 || bus.iter_left !== 16'd0)
      $display("FAIL t4_accept: busy=%b vld=%b iter=%0d want 0/0/0", bus.busy, bus.x_valid, bus.iter_left);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.X !== xs)
      $display("FAIL t4_idle: busy=%b X=%h want 0/%h", bus.busy, bus.X, xs);
    else n_pass++;
  endtask

  task automatic test_half_stats();
    int cnt [32];
    int samples = 0;
    int total = 0;
    int worst = 0;
    int bad = 0;
    int cyc = 0;
    logic [15:0] prev;
    for (int b = 0; b < 32; b++) cnt[b] = 0;
    setup(32'h0, 16'd4096, 7'd64, 8'h7F);
    pulse_start();
    prev = bus.iter_left;
    while (!bus.x_valid && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (bus.iter_left != prev) begin
        prev = bus.iter_left;
        samples++;
        for (int b = 0; b < 32; b++) cnt[b] += int'(bus.X[b]);
      end
    end
    for (int b = 1; b < 32; b++) begin
      total += cnt[b];
      if (cnt[b] < 1827 || cnt[b] > 2237) begin
        bad++;
        worst = cnt[b];
      end
    end
    n_checks++;
    if (samples != 4096 || cnt[0] != 4096)
      $display("FAIL t3_samples: samples=%0d x0_ones=%0d want 4096/4096", samples, cnt[0]);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL t3_per_bit: %0d bits out of range, e.g. %0d want 1827..2237", bad, worst);
    else n_pass++;
    n_checks++;
    if (total < 31 * 1930 || total > 31 * 2134)
      $display("FAIL t3_mean: ones=%0d want %0d..%0d", total, 31 * 1930, 31 * 2134);
    else n_pass++;
    if (bus.x_valid) accept();
  endtask

  task automatic test_reset_repeat();
    int diff = 0;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      setup(32'h0, 16'd5, 7'd64, 8'h7F);
      pulse_start();
      for (int k = 0; k < 9; k++) begin
        seq[r][k] = bus.X;
        @(negedge clk);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.X !== 32'h1 || bus.busy !== 1'b0 || bus.x_valid !== 1'b0 || bus.iter_left !== 16'd0)
        $display("FAIL t5_midreset: X=%h busy=%b vld=%b iter=%0d want 00000001/0/0/0",
                 bus.X, bus.busy, bus.x_valid, bus.iter_left);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
    end
    for (int k = 0; k < 9; k++) if (seq[0][k] !== seq[1][k]) diff++;
    n_checks++;
    if (diff != 0) $display("FAIL t5_repeat: %0d differing samples, first run X4=%h second X4=%h",
                            diff, seq[0][4], seq[1][4]);
    else n_pass++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x_ready = 1'b0;
    setup(32'h0, 16'd1, 7'd64, 8'h00);
    test_reset();
    test_mask_load();
    test_zero_planes();
    test_full_planes();
    test_backpressure();
    test_half_stats();
    test_reset_repeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
